// File: rtl/vga_pixel_output.sv
// VGA pixel output stage: FIFO fetch, active-area x/y tracking, RGB/sync delay.
// Optional colour-bar generator built when TEST_PATTERN_EN is defined.
module vga_pixel_output #(
    parameter int          H_ACTIVE        = 640,
    parameter int          V_ACTIVE        = 480,
    parameter logic [23:0] UNDERFLOW_COLOR = 24'hFF00FF
) (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic        blank_n_in,
    input  logic        pix_valid,
    input  logic [23:0] pix_data,
    input  logic        test_mode,
    output logic        pix_rd,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic [10:0] pos_x,
    output logic [9:0]  pos_y,
    output logic        frame_start,
    output logic [15:0] underflow_cnt
);

    typedef enum logic {WAIT_VS, RUN} state_t;

    localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

    state_t      state;
    logic        hs_d;
    logic        vs_d;
    logic        bl_d;
    logic [10:0] x_cnt;
    logic [9:0]  y_cnt;
    logic [15:0] live_cnt;
    logic [23:0] rgb_q;
    logic        vs_fall;
    logic        line_end;
    logic        test_path;
    logic [23:0] bar_rgb;
    logic        running;
    logic        underflow;

    assign vs_fall  = vs_d & ~vs_in;
    assign line_end = bl_d & ~blank_n_in;
    assign running  = (state == RUN);

`ifdef TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic [10:0] bar_idx;

    assign test_path = test_mode;
    assign bar_idx   = x_cnt / 11'(BAR_W);

    // Colour-bar lookup; anything past the eighth bar stays black.
    always_comb begin
        bar_rgb = 24'h000000;
        case (bar_idx)
            11'd0:   bar_rgb = 24'hFFFFFF;
            11'd1:   bar_rgb = 24'hFFFF00;
            11'd2:   bar_rgb = 24'h00FFFF;
            11'd3:   bar_rgb = 24'h00FF00;
            11'd4:   bar_rgb = 24'hFF00FF;
            11'd5:   bar_rgb = 24'hFF0000;
            11'd6:   bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end
`else
    logic unused_test_mode;

    assign test_path        = 1'b0;
    assign bar_rgb          = 24'h000000;
    assign unused_test_mode = test_mode;
`endif

    // Pop only when a pixel is actually consumed from the FIFO.
    assign pix_rd    = running & blank_n_in & pix_valid & ~test_path;
    assign underflow = running & blank_n_in & ~pix_valid & ~test_path;

    assign vga_hs      = hs_d;
    assign vga_vs      = vs_d;
    assign vga_blank_n = bl_d;
    assign vga_r       = rgb_q[23:16];
    assign vga_g       = rgb_q[15:8];
    assign vga_b       = rgb_q[7:0];

    // Fetch stays off after reset until the first frame boundary.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            state <= WAIT_VS;
        end else if (state == WAIT_VS && vs_fall) begin
            state <= RUN;
        end
    end

    // Sync/blank delay line, doubling as the edge-detect history.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            hs_d <= 1'b1;
            vs_d <= 1'b1;
            bl_d <= 1'b0;
        end else begin
            hs_d <= hs_in;
            vs_d <= vs_in;
            bl_d <= blank_n_in;
        end
    end

    // Active-area position counters, free-running from the sync inputs.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else begin
            if (!blank_n_in) begin
                x_cnt <= '0;
            end else begin
                x_cnt <= x_cnt + 11'd1;
            end
            if (vs_fall) begin
                y_cnt <= '0;
            end else if (line_end && y_cnt != Y_LAST) begin
                y_cnt <= y_cnt + 10'd1;
            end
        end
    end

    // Registered colour and position, aligned with the delayed syncs.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            rgb_q <= '0;
            pos_x <= '0;
            pos_y <= '0;
        end else begin
            pos_x <= x_cnt;
            pos_y <= y_cnt;
            if (!running || !blank_n_in) begin
                rgb_q <= '0;
            end else if (test_path) begin
                rgb_q <= bar_rgb;
            end else if (pix_valid) begin
                rgb_q <= pix_data;
            end else begin
                rgb_q <= UNDERFLOW_COLOR;
            end
        end
    end

    // Per-frame underflow tally; the frame-boundary clear wins over a count.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            live_cnt      <= '0;
            underflow_cnt <= '0;
            frame_start   <= 1'b0;
        end else begin
            frame_start <= vs_fall;
            if (vs_fall) begin
                underflow_cnt <= live_cnt;
                live_cnt      <= '0;
            end else if (underflow && live_cnt != 16'hFFFF) begin
                live_cnt <= live_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_pixel_output.sv
// Directed bench for vga_pixel_output on a reduced 16x8 raster
// (24 clocks per line, 12 lines per frame).
module tb_vga_pixel_output;

    localparam int HA = 16;
    localparam int VA = 8;
    localparam int HT = 24;
    localparam int VT = 12;
    localparam logic [23:0] UFC = 24'hFF00FF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        hs_in = 1'b1;
    logic        vs_in = 1'b1;
    logic        blank_n_in = 1'b0;
    logic        pix_valid = 1'b0;
    logic [23:0] pix_data = '0;
    logic        test_mode = 1'b0;
    logic        pix_rd;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_blank_n;
    logic [10:0] pos_x;
    logic [9:0]  pos_y;
    logic        frame_start;
    logic [15:0] underflow_cnt;

    vga_pixel_output #(
        .H_ACTIVE(HA),
        .V_ACTIVE(VA),
        .UNDERFLOW_COLOR(UFC)
    ) dut (
        .vga_clk(clk),
        .reset(reset),
        .hs_in(hs_in),
        .vs_in(vs_in),
        .blank_n_in(blank_n_in),
        .pix_valid(pix_valid),
        .pix_data(pix_data),
        .test_mode(test_mode),
        .pix_rd(pix_rd),
        .vga_r(vga_r),
        .vga_g(vga_g),
        .vga_b(vga_b),
        .vga_hs(vga_hs),
        .vga_vs(vga_vs),
        .vga_blank_n(vga_blank_n),
        .pos_x(pos_x),
        .pos_y(pos_y),
        .frame_start(frame_start),
        .underflow_cnt(underflow_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    int h = 0;
    int v = 3;
    bit run = 1'b0;
    bit drop_en = 1'b0;
    logic [23:0] head = 24'h000001;
    bit last_fall = 1'b0;

    int pops, rgb_bad, sync_bad, pos_bad, rd_bad, fs_cnt, uf_seen;
    logic [15:0] fs_ucnt;
    logic [23:0] first_rgb, first_exp;
    logic [10:0] first_x, last_x;
    logic [9:0]  first_y, last_y, sat_y;
    logic        first_bl;

    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF,
                              24'h00FF00, 24'hFF00FF, 24'hFF0000,
                              24'h0000FF, 24'h000000};

    task automatic clear_stats();
        pops = 0; rgb_bad = 0; sync_bad = 0; pos_bad = 0;
        rd_bad = 0; fs_cnt = 0; uf_seen = 0; fs_ucnt = 16'hDEAD;
    endtask

    // One pixel clock of raster stimulus plus per-cycle expectations.
    task automatic cyc();
        logic        pvs;
        logic        rd;
        logic        e_rd;
        logic [23:0] e_rgb;
        logic [23:0] got;
        pvs = vs_in;
        @(negedge clk);
        hs_in      = !(h >= 18 && h < 21);
        vs_in      = !(v >= 9 && v < 11);
        blank_n_in = (h < HA) && (v < VA);
        pix_valid  = !(drop_en && v == 2 && h >= 3 && h < 8);
        pix_data   = head;
        #1;
        rd = pix_rd;
        e_rd = run && blank_n_in && pix_valid && !test_mode;
        if (!run || !blank_n_in) e_rgb = 24'h0;
        else if (pix_valid) e_rgb = head;
        else e_rgb = UFC;
`ifdef TEST_PATTERN_EN
        if (run && blank_n_in && test_mode) e_rgb = bars[h / (HA / 8)];
`else
        e_rd = run && blank_n_in && pix_valid;
`endif
        last_fall = pvs && !vs_in;
        @(posedge clk);
        #1;
        got = {vga_r, vga_g, vga_b};
        if (rd !== e_rd) rd_bad++;
        if (got !== e_rgb) rgb_bad++;
        if (vga_hs !== hs_in || vga_vs !== vs_in) sync_bad++;
        if (vga_blank_n !== blank_n_in) sync_bad++;
        if (frame_start !== last_fall) sync_bad++;
        if (run && blank_n_in) begin
            if (pos_x !== 11'(h) || pos_y !== 10'(v)) pos_bad++;
            if (got === UFC) uf_seen++;
        end
        if (frame_start) begin fs_cnt++; fs_ucnt = underflow_cnt; end
        if (run && h == 0 && v == 0) begin
            first_rgb = got; first_exp = head;
            first_x = pos_x; first_y = pos_y; first_bl = vga_blank_n;
        end
        if (run && h == HA - 1 && v == VA - 1) begin
            last_x = pos_x; last_y = pos_y;
        end
        if (run && h == 2 && v == VA) sat_y = pos_y;
        if (rd) begin pops++; head = head + 24'd1; end
        if (last_fall) run = 1'b1;
        h++;
        if (h == HT) begin h = 0; v = (v + 1) % VT; end
    endtask

    task automatic run_to_vs_fall(input string name);
        int n;
        n = 0;
        last_fall = 1'b0;
        while (!last_fall && n < 2 * HT * VT) begin cyc(); n++; end
        if (!last_fall) begin
            total++; bad++;
            $display("FAIL %s_timeout no VS fall within %0d cycles", name, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        blank_n_in = 1'b1; pix_valid = 1'b1; hs_in = 1'b0; vs_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if ({vga_r, vga_g, vga_b} !== 24'h0) begin bad++;
            $display("FAIL rst_rgb got=%h exp=0", {vga_r, vga_g, vga_b}); end
        total++; if (vga_hs !== 1'b1 || vga_vs !== 1'b1) begin bad++;
            $display("FAIL rst_sync got=%b%b exp=11", vga_hs, vga_vs); end
        total++; if (vga_blank_n !== 1'b0) begin bad++;
            $display("FAIL rst_blank got=%b exp=0", vga_blank_n); end
        total++; if (pos_x !== 0 || pos_y !== 0) begin bad++;
            $display("FAIL rst_pos got=%0d,%0d exp=0,0", pos_x, pos_y); end
        total++; if (underflow_cnt !== 0 || frame_start !== 0) begin bad++;
            $display("FAIL rst_cnt got=%0d/%b exp=0/0", underflow_cnt, frame_start); end
        total++; if (pix_rd !== 1'b0) begin bad++;
            $display("FAIL rst_pix_rd got=%b exp=0", pix_rd); end
        @(negedge clk);
        hs_in = 1'b1; vs_in = 1'b1; blank_n_in = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_partial_frame();
        clear_stats();
        run_to_vs_fall("partial");
        total++; if (pops !== 0) begin bad++;
            $display("FAIL partial_pops got=%0d exp=0", pops); end
        total++; if (rgb_bad !== 0 || rd_bad !== 0) begin bad++;
            $display("FAIL partial_rgb got=%0d/%0d bad cycles exp=0", rgb_bad, rd_bad); end
        total++; if (sync_bad !== 0 || fs_cnt !== 1) begin bad++;
            $display("FAIL partial_sync got=%0d/%0d exp=0/1", sync_bad, fs_cnt); end
    endtask

    task automatic test_full_frame();
        clear_stats();
        run_to_vs_fall("frame");
        total++; if (pops !== HA * VA) begin bad++;
            $display("FAIL frame_pops got=%0d exp=%0d", pops, HA * VA); end
        total++; if (rgb_bad !== 0 || rd_bad !== 0) begin bad++;
            $display("FAIL frame_rgb got=%0d/%0d bad cycles exp=0", rgb_bad, rd_bad); end
        total++; if (pos_bad !== 0) begin bad++;
            $display("FAIL frame_pos got=%0d bad cycles exp=0", pos_bad); end
        total++; if (sync_bad !== 0 || fs_cnt !== 1) begin bad++;
            $display("FAIL frame_sync got=%0d/%0d exp=0/1", sync_bad, fs_cnt); end
        total++; if (first_rgb !== first_exp || first_bl !== 1'b1) begin bad++;
            $display("FAIL first_pix got=%h/%b exp=%h/1", first_rgb, first_bl, first_exp); end
        total++; if (first_x !== 0 || first_y !== 0) begin bad++;
            $display("FAIL first_pos got=%0d,%0d exp=0,0", first_x, first_y); end
        total++; if (last_x !== 11'(HA - 1) || last_y !== 10'(VA - 1)) begin bad++;
            $display("FAIL last_pos got=%0d,%0d exp=%0d,%0d", last_x, last_y, HA - 1, VA - 1); end
        total++; if (sat_y !== 10'(VA - 1)) begin bad++;
            $display("FAIL y_sat got=%0d exp=%0d", sat_y, VA - 1); end
        total++; if (fs_ucnt !== 16'd0) begin bad++;
            $display("FAIL frame_ucnt got=%0d exp=0", fs_ucnt); end
    endtask

    task automatic test_underflow();
        clear_stats();
        drop_en = 1'b1;
        run_to_vs_fall("uf");
        drop_en = 1'b0;
        total++; if (uf_seen !== 5) begin bad++;
            $display("FAIL uf_pixels got=%0d exp=5", uf_seen); end
        total++; if (pops !== HA * VA - 5) begin bad++;
            $display("FAIL uf_pops got=%0d exp=%0d", pops, HA * VA - 5); end
        total++; if (rgb_bad !== 0 || rd_bad !== 0) begin bad++;
            $display("FAIL uf_rgb got=%0d/%0d bad cycles exp=0", rgb_bad, rd_bad); end
        total++; if (fs_ucnt !== 16'd5) begin bad++;
            $display("FAIL uf_cnt got=%0d exp=5", fs_ucnt); end
        clear_stats();
        run_to_vs_fall("uf_clean");
        total++; if (fs_ucnt !== 16'd0) begin bad++;
            $display("FAIL uf_clean_cnt got=%0d exp=0", fs_ucnt); end
    endtask

    task automatic test_reset_mid();
        clear_stats();
        while (!(v == 2 && h == 5)) cyc();
        total++; if (rgb_bad !== 0 || pix_rd !== 1'b1) begin bad++;
            $display("FAIL mid_pre got=%0d/%b exp=0/1", rgb_bad, pix_rd); end
        #2;
        reset = 1'b1;
        run = 1'b0;
        #1;
        total++; if ({vga_r, vga_g, vga_b} !== 24'h0 || pix_rd !== 1'b0) begin bad++;
            $display("FAIL mid_rst got=%h/%b exp=0/0", {vga_r, vga_g, vga_b}, pix_rd); end
        total++; if (pos_x !== 0 || pos_y !== 0 || vga_blank_n !== 1'b0) begin bad++;
            $display("FAIL mid_rst_pos got=%0d,%0d,%b exp=0,0,0", pos_x, pos_y, vga_blank_n); end
        @(negedge clk);
        reset = 1'b0;
        clear_stats();
        run_to_vs_fall("mid_wait");
        total++; if (pops !== 0 || rgb_bad !== 0) begin bad++;
            $display("FAIL mid_wait got=%0d pops/%0d bad exp=0/0", pops, rgb_bad); end
        clear_stats();
        run_to_vs_fall("mid_resume");
        total++; if (pops !== HA * VA || rgb_bad !== 0 || pos_bad !== 0) begin bad++;
            $display("FAIL mid_resume got=%0d/%0d/%0d exp=%0d/0/0", pops, rgb_bad, pos_bad, HA * VA); end
    endtask

`ifdef TEST_PATTERN_EN
    task automatic test_pattern();
        clear_stats();
        test_mode = 1'b1;
        run_to_vs_fall("bars");
        test_mode = 1'b0;
        total++; if (pops !== 0 || rd_bad !== 0) begin bad++;
            $display("FAIL bars_pops got=%0d/%0d exp=0/0", pops, rd_bad); end
        total++; if (rgb_bad !== 0) begin bad++;
            $display("FAIL bars_rgb got=%0d bad cycles exp=0", rgb_bad); end
        total++; if (fs_ucnt !== 16'd0) begin bad++;
            $display("FAIL bars_ucnt got=%0d exp=0", fs_ucnt); end
    endtask
`endif

    initial begin
        clear_stats();
        test_reset();
        test_partial_frame();
        test_full_frame();
        test_underflow();
        test_reset_mid();
`ifdef TEST_PATTERN_EN
        test_pattern();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_pixel_output.md
Name: vga_pixel_output

Overview:
- Downstream consumer of the VGA sync generator's HS, VS and blank_n.
- Pulls pixels from a show-ahead pixel FIFO during the active area and tracks the active-area x/y position.
- Drives registered RGB plus delayed syncs so colour and sync reach the DAC aligned.
- Flags FIFO underflow and holds pixel fetch off until the first frame boundary after reset.

Parameters:
H_ACTIVE, 640, active pixels per line; sets the test-bar width to H_ACTIVE/8
V_ACTIVE, 480, active lines per frame; pos_y saturates at V_ACTIVE-1
UNDERFLOW_COLOR, 24'hFF00FF, RGB driven on any active pixel with no FIFO data

Ports:
vga_clk  in  1  pixel clock; block uses rising edge (upstream updates on falling edge)
reset  in  1  asynchronous, active-high
hs_in  in  1  horizontal sync from sync generator, active-low
vs_in  in  1  vertical sync from sync generator, active-low
blank_n_in  in  1  high = active pixel
pix_valid  in  1  FIFO not empty; pix_data is valid
pix_data  in  24  {R[7:0],G[7:0],B[7:0]}, show-ahead
test_mode  in  1  selects colour bars (used only with TEST_PATTERN_EN)
pix_rd  out  1  FIFO pop, combinational
vga_r  out  8  red
vga_g  out  8  green
vga_b  out  8  blue
vga_hs  out  1  hs_in delayed 1 cycle
vga_vs  out  1  vs_in delayed 1 cycle
vga_blank_n  out  1  blank_n_in delayed 1 cycle
pos_x  out  11  x of pixel currently on RGB
pos_y  out  10  y of pixel currently on RGB
frame_start  out  1  1-cycle pulse on VS falling edge
underflow_cnt  out  16  underflow pixels counted in the previous frame, saturating

Behaviour:
- Reset values:
  - vga_r/g/b, pos_x, pos_y, underflow_cnt, frame_start = 0.
  - vga_hs, vga_vs, vga_blank_n = 1, 1, 0.
  - FSM = WAIT_VS.
- Edge detect: registers hs_d, vs_d, bl_d hold the previous inputs.
  - VS fall = vs_d & ~vs_in.
  - Line end = bl_d & ~blank_n_in.
- FSM:
  - WAIT_VS:
    - pix_rd = 0.
    - RGB = 0.
    - Syncs and vga_blank_n still pass through with 1-cycle delay.
    - On VS fall, go to RUN.
  - RUN:
    - Stays in RUN until reset.
    - Never returns to WAIT_VS; underflow slips pixels but does not resync.
- pix_rd = (state==RUN) & blank_n_in & pix_valid & ~test_path, where test_path is defined under Optional Feature. pix_rd never asserts when pix_valid=0.
- Output stage, 1-cycle latency, all outputs registered:
  - ~blank_n_in: RGB <= 0.
  - blank_n_in & pix_valid: RGB <= pix_data.
  - blank_n_in & ~pix_valid: RGB <= UNDERFLOW_COLOR, and the live underflow counter increments (saturates at 16'hFFFF).
- Coordinates:
  - x counter: cleared whenever blank_n_in=0; increments each active cycle. pos_x <= x counter, registered alongside RGB.
  - y counter: cleared on VS fall; increments on line end, saturating at V_ACTIVE-1. pos_y <= y counter.
  - First active line after VS is y=0.
  - Counters run in WAIT_VS too.
- Frame boundary (VS fall):
  - frame_start pulses high the next cycle.
  - underflow_cnt <= live counter; live counter cleared.
  - If an underflow occurs on the same cycle, the clear wins and that underflow is dropped (cannot occur with legal timing, since VS is in blanking).
- Reset mid-frame: all state returns to reset values immediately. Fetch resumes only after the next VS fall.

Optional Feature:
- Macro TEST_PATTERN_EN.
- Defined: test_path = test_mode.
  - When test_mode=1: pix_rd=0 and active RGB = 8 vertical bars, each H_ACTIVE/8 pixels wide, selected by x counter / (H_ACTIVE/8).
  - Bar order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - No underflow counting in test mode.
- Undefined: test_path = 0; test_mode port present but ignored; no bar logic synthesized.

Test Plan:
- Reset, then 640x480 timing (800x525) with pix_valid=1 and pix_data = incrementing count -> pix_rd=0 and RGB=0 throughout the first partial frame. After VS fall: exactly 640 pops per active line, 307200 per frame.
- Steady state -> pixel 0 of line 0 appears one cycle after blank_n_in rises, with pos_x=0, pos_y=0 and vga_blank_n=1. Last pixel of the frame shows pos_x=639, pos_y=479.
- Syncs -> vga_hs/vga_vs/vga_blank_n equal inputs delayed exactly 1 cycle. frame_start is high for exactly 1 cycle per frame.
- Drop pix_valid for 5 active cycles on line 10 -> those 5 outputs are FF00FF with pix_rd=0. Next frame_start: underflow_cnt=5. Following clean frame: underflow_cnt=0.
- Assert reset at line 200 mid-line -> outputs return to reset values at once. pix_rd stays 0 until the next VS fall, then line 0 fetches normally.
- TEST_PATTERN_EN defined, test_mode=1 -> pix_rd=0. Pixels 0..79 = FFFFFF, 80..159 = FFFF00, ..., 560..639 = 000000.
